cbd_sampler_stream: RTL
=======================

// Module: cbd_sampler_stream
// PURPOSE
//  Streaming, parametrised successor of the single-shot CBD sampler. Consumes uniform
//  random words (PRF/SHAKE output) on a valid/ready input. Produces one full Kyber
//  polynomial of N centred-binomial coefficients, LANES per beat, reduced mod Q.
//  ETA (2 or 3) is selectable per polynomial. An internal bit buffer handles coefficient
//  groups that straddle word boundaries. Sits between the Keccak PRF and the NTT input.
// PARAMETERS
//  LANES      4     coefficients per output beat; N % LANES == 0
//  RAND_WIDTH 128   random input word width; must be >= 6*LANES
//  COEF_BITS  12    output coefficient width; must hold Q-1
//  Q          3329  modulus
//  N          256   coefficients per polynomial
// PORTS
//  clk        in   1                clock, rising edge
//  reset      in   1                asynchronous, active-high; clears all state
//  start      in   1                begin one polynomial; sampled only in IDLE
//  eta_sel    in   1                0: ETA=2, 1: ETA=3; latched when start is accepted
//  rand_valid in   1                random word valid
//  rand_ready out  1                block can accept rand_data this cycle
//  rand_data  in   RAND_WIDTH       random bits, consumed LSB first
//  coef_valid out  1                coef_data valid
//  coef_ready in   1                downstream accepts beat
//  coef_data  out  LANES*COEF_BITS  lane i at [i*COEF_BITS +: COEF_BITS], value in [0,Q-1]
//  coef_last  out  1                marks beat N/LANES of the polynomial
//  busy       out  1                high in RUN
//  done       out  1                one-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  - Reset values: rand_ready=0, coef_valid=0, coef_data=0, coef_last=0, busy=0,
//    done=0. Buffer, bit_cnt and beat_cnt are cleared. FSM enters IDLE.
//  - One clock and one asynchronous active-high reset (clk, reset). Reset mid-polynomial
//    aborts immediately. Partial output is lost and no done pulse is issued.
//  - FSM states: IDLE, RUN.
//    - IDLE->RUN when start=1: latch eta_sel, clear bit_cnt and beat_cnt.
//    - RUN->IDLE on the edge that accepts the beat with coef_last=1. done=1 for the
//      following cycle.
//    - start while in RUN is ignored.
//  - NEED = 2*ETA*LANES bits per beat. Buffer width is NEED_MAX-1+RAND_WIDTH, with
//    NEED_MAX = 6*LANES.
//  - rand_ready = RUN && (bit_cnt < NEED). A word is appended at bit position bit_cnt and
//    bit_cnt increases by RAND_WIDTH.
//  - A beat is produced when RUN, bit_cnt >= NEED and (!coef_valid || coef_ready).
//    Producing a beat does the following:
//    - Load the output register from buffer bits [NEED-1:0].
//    - Shift the buffer right by NEED and decrease bit_cnt by NEED.
//  - Load and produce are mutually exclusive in a cycle (ready requires bit_cnt < NEED).
//  - Latency: a word accepted at edge k gives coef_valid=1 from edge k+1.
//  - Coefficient j of a beat:
//    - a = popcount(bits[2ETA*j +: ETA]) and b = popcount(next ETA bits).
//    - c = a-b. Output c if c>=0, otherwise c+Q.
//  - coef_data and coef_last are held stable while coef_valid=1 and coef_ready=0.
//  - beat_cnt increments on each accepted beat. coef_last=1 when beat_cnt == N/LANES-1.
//  - Leftover buffer bits after the last beat are discarded. The next polynomial starts
//    with an empty buffer.
//  - Default words consumed per polynomial: exactly 8 for ETA=2 and 12 for ETA=3.
//    With ETA=3 and LANES=4, beats straddle word boundaries (128 % 24 != 0).
// TESTING
//  1. eta_sel=0; 8 all-zero words; coef_ready=1 -> 64 beats of zeros, coef_last on
//     beat 64, done one cycle later, rand_ready never high for a 9th word.
//  2. eta_sel=0; words of all 0xC3 bytes -> every beat lanes {2,3327,2,3327}
//     (lane0 in LSBs).
//  3. eta_sel=1; word0=0, word1=all-ones, rest 0 -> beat 6 (bits 120..143) =
//     {0,3327,0,0} lane0..3. Beats 7..10 are all 0. No bits are lost at the boundary.
//  4. eta_sel=1; bits repeating 6'b000111 from bit 0 -> lanes 3. Then 6'b111000 ->
//     lanes 3326. Covers both reduction paths.
//  5. Backpressure: coef_ready=0 for 10 cycles mid-run -> coef_data/coef_last stable,
//     rand_ready=0 once bit_cnt>=NEED. Full 256-coefficient stream matches the model.
//     start pulsed during RUN has no effect.
//  6. Assert reset at beat 20 -> next cycle all outputs 0, IDLE. A new start gives a
//     clean polynomial starting from coefficient 0.

Source files
------------

// File: rtl/cbd_sampler_stream.sv
// rtl/cbd_sampler_stream.sv - streaming centred-binomial sampler, LANES coefficients per beat
module cbd_sampler_stream #(
    parameter int LANES      = 4,
    parameter int RAND_WIDTH = 128,
    parameter int COEF_BITS  = 12,
    parameter int Q          = 3329,
    parameter int N          = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         eta_sel,
    input  logic                         rand_valid,
    output logic                         rand_ready,
    input  logic [RAND_WIDTH-1:0]        rand_data,
    output logic                         coef_valid,
    input  logic                         coef_ready,
    output logic [LANES*COEF_BITS-1:0]   coef_data,
    output logic                         coef_last,
    output logic                         busy,
    output logic                         done
);

    localparam int NEED_MAX = 6 * LANES;
    localparam int BUF_W    = NEED_MAX - 1 + RAND_WIDTH;
    localparam int CNT_W    = $clog2(BUF_W + 1);
    localparam int BEATS    = N / LANES;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state_q, state_d;
    logic [BUF_W-1:0]             buf_q, buf_d;
    logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic                         eta_q, eta_d;
    logic                         coef_valid_q, coef_valid_d;
    logic [LANES*COEF_BITS-1:0]   coef_data_q, coef_data_d;
    logic                         done_q, done_d;

    logic [CNT_W-1:0]             need;
    logic [LANES*COEF_BITS-1:0]   lanes_c;
    logic [1:0]                   pa, pb;
    logic                         last_held, accept, load, produce;

    assign need      = eta_q ? CNT_W'(6 * LANES) : CNT_W'(4 * LANES);
    // Once the final beat sits in the output register no more input is wanted.
    assign last_held = coef_valid_q && (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign accept    = coef_valid_q && coef_ready;
    assign rand_ready = (state_q == RUN) && (bit_cnt_q < need) && !last_held;
    assign load      = rand_ready && rand_valid;
    assign produce   = (state_q == RUN) && (bit_cnt_q >= need) &&
                       (!coef_valid_q || coef_ready) && !last_held;

    always_comb begin
        lanes_c = '0;
        pa      = '0;
        pb      = '0;
        for (int j = 0; j < LANES; j++) begin
            if (eta_q) begin
                pa = {1'b0, buf_q[6*j]}   + {1'b0, buf_q[6*j+1]} + {1'b0, buf_q[6*j+2]};
                pb = {1'b0, buf_q[6*j+3]} + {1'b0, buf_q[6*j+4]} + {1'b0, buf_q[6*j+5]};
            end else begin
                pa = {1'b0, buf_q[4*j]}   + {1'b0, buf_q[4*j+1]};
                pb = {1'b0, buf_q[4*j+2]} + {1'b0, buf_q[4*j+3]};
            end
            if (pa >= pb) begin
                lanes_c[j*COEF_BITS +: COEF_BITS] = COEF_BITS'(pa - pb);
            end else begin
                lanes_c[j*COEF_BITS +: COEF_BITS] = COEF_BITS'(Q) - COEF_BITS'(pb - pa);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        bit_cnt_d    = bit_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        eta_d        = eta_q;
        coef_valid_d = coef_valid_q;
        coef_data_d  = coef_data_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    eta_d      = eta_sel;
                    buf_d      = '0;
                    bit_cnt_d  = '0;
                    beat_cnt_d = '0;
                end
            end
            RUN: begin
                if (load) begin
                    buf_d     = buf_q | (BUF_W'(rand_data) << bit_cnt_q);
                    bit_cnt_d = bit_cnt_q + CNT_W'(RAND_WIDTH);
                end
                if (accept) begin
                    coef_valid_d = 1'b0;
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                end
                if (produce) begin
                    coef_valid_d = 1'b1;
                    coef_data_d  = lanes_c;
                    buf_d        = buf_q >> need;
                    bit_cnt_d    = bit_cnt_q - need;
                end
                if (accept && last_held) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            bit_cnt_q    <= '0;
            beat_cnt_q   <= '0;
            eta_q        <= 1'b0;
            coef_valid_q <= 1'b0;
            coef_data_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            bit_cnt_q    <= bit_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            eta_q        <= eta_d;
            coef_valid_q <= coef_valid_d;
            coef_data_q  <= coef_data_d;
            done_q       <= done_d;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef_data  = coef_data_q;
    assign coef_last  = last_held;
    assign busy       = (state_q == RUN);
    assign done       = done_q;

endmodule
